// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a req/ack handshake, fixed ack latency and a preload side port.
// Out-of-range accesses are still acked but flagged on addr_err.
module ram_responder #(
    parameter int unsigned RAMSIZE = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ramAddress,
    input  logic [31:0] ramOut,
    input  logic        readReq,
    input  logic        writeReq,
    output logic [31:0] ramIn,
    output logic        readAck,
    output logic        writeAck,
    input  logic        load_we,
    input  logic [5:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        addr_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_t;

    localparam logic [6:0] RamSizeW = 7'(RAMSIZE);
    // Counter starts at LATENCY-1 so the ack lands exactly LATENCY edges after acceptance.
    localparam logic [3:0] CountLoad = 4'(LATENCY - 1);

    state_t      r_state;
    logic        r_op_write;
    logic [5:0]  r_index;
    logic [31:0] r_wdata;
    logic [3:0]  r_count;
    logic [31:0] r_ram_in;
    logic        r_read_ack;
    logic        r_write_ack;
    logic        r_addr_err;
    logic        r_busy;
    logic [31:0] r_mem [0:63];

    logic w_req_active;
    logic w_commit;
    logic w_in_range;
    logic w_load_ok;
    logic w_unused_addr_lsb;

    assign w_req_active      = r_op_write ? writeReq : readReq;
    assign w_commit          = (r_state == StWait) && w_req_active && (r_count == 4'd0);
    assign w_in_range        = {1'b0, r_index} < RamSizeW;
    assign w_load_ok         = load_we && ({1'b0, load_addr} < RamSizeW);
    assign w_unused_addr_lsb = ^ramAddress[1:0];

    // Memory is deliberately outside the reset domain; the later load write wins on a collision.
    always_ff @(posedge clk) begin
        if (w_commit && r_op_write && w_in_range) begin
            r_mem[r_index] <= r_wdata;
        end
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_op_write  <= 1'b0;
            r_index     <= 6'd0;
            r_wdata     <= 32'h0;
            r_count     <= 4'd0;
            r_ram_in    <= 32'h0;
            r_read_ack  <= 1'b0;
            r_write_ack <= 1'b0;
            r_addr_err  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (readReq) begin
                        r_index    <= ramAddress[7:2];
                        r_op_write <= 1'b0;
                        r_count    <= CountLoad;
                        r_state    <= StWait;
                        r_busy     <= 1'b1;
                    end else if (writeReq) begin
                        r_index    <= ramAddress[7:2];
                        r_wdata    <= ramOut;
                        r_op_write <= 1'b1;
                        r_count    <= CountLoad;
                        r_state    <= StWait;
                        r_busy     <= 1'b1;
                    end
                end
                StWait: begin
                    if (!w_req_active) begin
                        r_count <= 4'd0;
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (r_count == 4'd0) begin
                        r_state    <= StAck;
                        r_addr_err <= !w_in_range;
                        if (r_op_write) begin
                            r_write_ack <= 1'b1;
                        end else begin
                            r_read_ack <= 1'b1;
                            // Forward a same-edge preload so the read never returns stale data.
                            if (!w_in_range) begin
                                r_ram_in <= 32'h0;
                            end else if (w_load_ok && (load_addr == r_index)) begin
                                r_ram_in <= load_data;
                            end else begin
                                r_ram_in <= r_mem[r_index];
                            end
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                StAck: begin
                    if (!w_req_active) begin
                        r_read_ack  <= 1'b0;
                        r_write_ack <= 1'b0;
                        r_state     <= StRelease;
                    end
                end
                StRelease: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ramIn    = r_ram_in;
    assign readAck  = r_read_ack;
    assign writeAck = r_write_ack;
    assign addr_err = r_addr_err;
    assign busy     = r_busy;

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter RAMSIZE, default 64, meaning number of 32-bit words in the memory array (max 64).
REQ-002 Parameter LATENCY, default 2, meaning clock edges from request acceptance to ack assertion; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ramAddress  input  8  byte address from initiator; word index = ramAddress[7:2], bits [1:0] ignored.
REQ-006 ramOut  input  32  write data from initiator.
REQ-007 readReq  input  1  read request, level, held until readAck seen.
REQ-008 writeReq  input  1  write request, level, held until writeAck seen.
REQ-009 ramIn  output  32  read data to initiator.
REQ-010 readAck  output  1  read acknowledge.
REQ-011 writeAck  output  1  write acknowledge.
REQ-012 load_we  input  1  side-port preload write enable, single cycle.
REQ-013 load_addr  input  6  side-port word index.
REQ-014 load_data  input  32  side-port write data.
REQ-015 addr_err  output  1  one-cycle pulse: accepted request addressed word index >= RAMSIZE.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 States: IDLE, WAIT, ACK, RELEASE; encoding free.
REQ-018 IDLE, readReq=1 sampled: latch word index, op=READ, load counter, go WAIT.
REQ-019 IDLE, writeReq=1 (readReq=0) sampled: latch word index and ramOut, op=WRITE, load counter, go WAIT.
REQ-020 Both requests high in IDLE: read accepted first; write stays pending and is accepted from IDLE after the read completes.
REQ-021 Ack (readAck or writeAck per op) rises at edge E0+LATENCY, where E0 = accepting edge; state enters ACK on that edge.
REQ-022 READ: ramIn updated to mem[index] on the same edge ack rises; ramIn holds that value until the next read ack.
REQ-023 WRITE: mem[index] <= latched data on the same edge ack rises; ramIn unchanged.
REQ-024 ACK: ack held high while the active request stays 1; first edge sampling request=0 clears ack, goes RELEASE.
REQ-025 RELEASE: one cycle, no acceptance, returns to IDLE; new requests are sampled from IDLE only.
REQ-026 Request dropped during WAIT: abort; go IDLE next edge, no ack, no memory write, ramIn unchanged.
REQ-027 Index >= RAMSIZE: transaction still acked with normal timing; read returns 32'h0; write discarded; addr_err pulses high for one cycle coincident with ack rise.
REQ-028 readAck and writeAck are never high simultaneously.
REQ-029 load_we=1: mem[load_addr] <= load_data that edge, in any state; ignored if load_addr >= RAMSIZE.
REQ-030 Load and bus write commit to the same word on the same edge: load data wins.
REQ-031 Load to the word of an in-flight read before ack: read returns the loaded value.
REQ-032 Latency counter: 4 bits, saturates at 0, no wrap.

Reset
REQ-033 reset=1 asynchronously forces state=IDLE, readAck=0, writeAck=0, addr_err=0, busy=0, ramIn=32'h0, counter=0.
REQ-034 Memory contents are not modified by reset; reset mid-transaction drops ack and abandons any uncommitted write.
REQ-035 After reset release, the first request is accepted on the first edge it is sampled high.

Verification
REQ-036 Preload word 1 = 32'hDEADBEEF via load port; readReq with ramAddress=8'h04, LATENCY=2 -> readAck high 2 edges after acceptance, ramIn=32'hDEADBEEF, ack stays high until readReq drops, clears one edge later.
REQ-037 writeReq, ramAddress=8'h08, ramOut=32'h12345678, then readReq at 8'h0B -> writeAck then readAck, ramIn=32'h12345678.
REQ-038 readReq and writeReq raised the same cycle at 8'h00 -> readAck completes first, writeAck follows after RELEASE/IDLE, never overlapping.
REQ-039 With RAMSIZE=16, readReq at 8'h40 -> readAck with ramIn=32'h0, addr_err one-cycle pulse; writeReq at 8'h40 leaves memory unchanged.
REQ-040 writeReq dropped one cycle after acceptance (LATENCY=3) -> no writeAck, target word unchanged, busy low within 1 edge.
REQ-041 Assert reset in ACK state of a read -> readAck=0, busy=0 immediately; previously written words retain their values when read after reset.
